// File: rtl/dff_sync_reset.sv
// D flop with synchronous active-high reset to RST_VAL; Q follows D one clk later.
// No flow control; the register accepts a new value on every rising edge.
module dff_sync_reset #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Reset wins over D; nothing but the clock edge can move the register.
  always_comb begin
    q_d = D;
    if (reset) begin
      q_d = RST_VAL;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: tb/tb_dff_sync_reset.sv
// Bench for dff_sync_reset: default 1-bit instance and an 8-bit instance resetting to 8'hA5.
module tb_dff_sync_reset;

  localparam logic [7:0] RST8 = 8'hA5;

  logic       clk;
  logic       reset;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks   = 0;
  int failures = 0;

  // Expected register contents, derived only from what the flop should hold.
  logic [7:0] exp1;
  logic [7:0] exp8;

  dff_sync_reset u_dut1 (
    .clk   (clk),
    .reset (reset),
    .D     (d1),
    .Q     (q1)
  );

  dff_sync_reset #(
    .WIDTH   (8),
    .RST_VAL (RST8)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .D     (d8),
    .Q     (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at edge+1. Inputs are scrambled mid-cycle (including reset), then
  // settled to the requested values at edge+8; Q must not move until the next edge.
  task automatic cycle(input logic r, input logic dv1, input logic [7:0] dv8, input string tag);
    #1;
    reset = 1'($urandom);
    d1    = 1'($urandom);
    d8    = 8'($urandom);
    #2;
    reset = ~reset;
    d8    = ~d8;
    #4;
    reset = r;
    d1    = dv1;
    d8    = dv8;
    #1;
    chk({tag, "_hold1"}, {7'd0, q1}, exp1);
    chk({tag, "_hold8"}, q8, exp8);
    exp1 = r ? 8'd0 : {7'd0, dv1};
    exp8 = r ? RST8 : dv8;
    @(posedge clk);
    #1;
    chk({tag, "_q1"}, {7'd0, q1}, exp1);
    chk({tag, "_q8"}, q8, exp8);
  endtask

  initial begin
    logic       r;
    logic       b;
    logic [7:0] v;

    reset = 1'b1;
    d1    = 1'b0;
    d8    = 8'h00;
    @(posedge clk);
    #1;
    exp1 = 8'd0;
    exp8 = RST8;
    chk("pwrup_q1", {7'd0, q1}, exp1);
    chk("pwrup_q8", q8, exp8);

    cycle(1'b0, 1'b0, 8'h3C, "rst_drop");
    cycle(1'b0, 1'b1, 8'h3C, "cap_one");
    cycle(1'b0, 1'b0, 8'hC3, "cap_zero");
    cycle(1'b0, 1'b1, 8'hFF, "set_one");
    cycle(1'b1, 1'b1, 8'h5A, "rst_mid");
    cycle(1'b1, 1'b1, 8'hFF, "rst_prio");
    cycle(1'b0, 1'b1, 8'h3C, "rst_rel");
    cycle(1'b0, 1'b1, 8'h00, "hold_zero");

    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 3) == 0);
      b = 1'($urandom);
      v = 8'($urandom);
      cycle(r, b, v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
